// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and read/write helpers for register_file_mp
package register_file_pkg;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_SEND = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_t;

   typedef enum logic [1:0] {
      RD_ZERO   = 2'd0,
      RD_BYPASS = 2'd1,
      RD_STORE  = 2'd2
   } rd_sel_t;

   function automatic logic wr_effective(input logic        wr_en,
                                         input int unsigned wr_addr,
                                         input int unsigned n_regs,
                                         input logic        zero_reg);
      return wr_en && (wr_addr < n_regs) && !(zero_reg && (wr_addr == 0));
   endfunction

   // Chooses the source of a bypassed read; width-independent so any port can share it.
   function automatic rd_sel_t rd_select(input int unsigned rd_addr,
                                         input logic        wr_eff,
                                         input int unsigned wr_addr,
                                         input int unsigned n_regs,
                                         input logic        zero_reg);
      if ((rd_addr >= n_regs) || (zero_reg && (rd_addr == 0)))
         return RD_ZERO;
      if (wr_eff && (wr_addr == rd_addr))
         return RD_BYPASS;
      return RD_STORE;
   endfunction

endpackage

// File: rtl/register_dump_fsm.sv
// rtl/register_dump_fsm.sv - handshaked engine streaming every register as a snapshot beat
module register_dump_fsm
   import register_file_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDRESS  = 5,
   parameter int N_REGISTERS = 32
)
(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_ready,
   input  logic [NB_DATA-1:0]    i_load_data,
   output logic [NB_ADDRESS-1:0] o_load_addr,
   output logic                  o_valid,
   output logic [NB_ADDRESS-1:0] o_addr,
   output logic [NB_DATA-1:0]    o_data,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_REGISTERS - 1);

   dump_state_t             state;
   dump_state_t             state_next;
   logic                    load;
   logic [NB_ADDRESS-1:0]   addr;
   logic [NB_DATA-1:0]      data;

   // The parent answers this address with a bypassed read, captured on load.
   assign o_load_addr = (state == DUMP_SEND) ? addr + NB_ADDRESS'(1) : '0;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         DUMP_IDLE: begin
            if (i_start) begin
               load       = 1'b1;
               state_next = DUMP_SEND;
            end
         end
         DUMP_SEND: begin
            if (i_ready) begin
               if (addr == LAST_ADDR)
                  state_next = DUMP_DONE;
               else
                  load = 1'b1;
            end
         end
         DUMP_DONE: state_next = DUMP_IDLE;
         default:   state_next = DUMP_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= DUMP_IDLE;
         addr  <= '0;
         data  <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            addr <= o_load_addr;
            data <= i_load_data;
         end
      end
   end

   assign o_valid = (state == DUMP_SEND);
   assign o_busy  = (state != DUMP_IDLE);
   assign o_done  = (state == DUMP_DONE);
   assign o_addr  = addr;
   assign o_data  = data;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and dump engine
module register_file_mp
   import register_file_pkg::*;
#(
   parameter int NB_DATA      = 32,
   parameter int NB_ADDRESS   = 5,
   parameter int N_REGISTERS  = 32,
   parameter int N_READ_PORTS = 2,
   parameter int ZERO_REG     = 1
)
(
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic                             i_wr_en,
   input  logic [NB_ADDRESS-1:0]            i_wr_addr,
   input  logic [NB_DATA-1:0]               i_wr_data,
   input  logic [N_READ_PORTS*NB_ADDRESS-1:0] i_rd_addr,
   output logic [N_READ_PORTS*NB_DATA-1:0]  o_rd_data,
   input  logic                             i_dump_start,
   input  logic                             i_dump_ready,
   output logic                             o_dump_valid,
   output logic [NB_ADDRESS-1:0]            o_dump_addr,
   output logic [NB_DATA-1:0]               o_dump_data,
   output logic                             o_dump_busy,
   output logic                             o_dump_done
);

   localparam int   N_PORTS = N_READ_PORTS + 1;
   localparam logic ZERO    = (ZERO_REG != 0);

   logic [NB_DATA-1:0]            regs [N_REGISTERS];
   logic                          wr_eff;
   logic [NB_ADDRESS-1:0]         dump_load_addr;
   logic [NB_DATA-1:0]            dump_load_data;
   logic [N_PORTS*NB_ADDRESS-1:0] rd_addr_all;
   logic [N_PORTS*NB_DATA-1:0]    rd_data_all;

   assign wr_eff = wr_effective(i_wr_en, 32'(i_wr_addr), N_REGISTERS, ZERO);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int r = 0; r < N_REGISTERS; r++)
            regs[r] <= '0;
      end else if (wr_eff) begin
         regs[i_wr_addr] <= i_wr_data;
      end
   end

   // The topmost port is private to the dump engine for its next beat.
   assign rd_addr_all    = {dump_load_addr, i_rd_addr};
   assign o_rd_data      = rd_data_all[N_READ_PORTS*NB_DATA-1:0];
   assign dump_load_data = rd_data_all[N_READ_PORTS*NB_DATA +: NB_DATA];

   for (genvar k = 0; k < N_PORTS; k++) begin : g_rd
      logic [NB_ADDRESS-1:0] addr;
      logic [NB_DATA-1:0]    data;

      assign addr = rd_addr_all[k*NB_ADDRESS +: NB_ADDRESS];

      always_comb begin
         data = '0;
         case (rd_select(32'(addr), wr_eff, 32'(i_wr_addr), N_REGISTERS, ZERO))
            RD_BYPASS: data = i_wr_data;
            RD_STORE:  data = regs[addr];
            default:   data = '0;
         endcase
      end

      assign rd_data_all[k*NB_DATA +: NB_DATA] = data;
   end

   register_dump_fsm #(
      .NB_DATA     (NB_DATA),
      .NB_ADDRESS  (NB_ADDRESS),
      .N_REGISTERS (N_REGISTERS)
   ) u_dump (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (i_dump_start),
      .i_ready     (i_dump_ready),
      .i_load_data (dump_load_data),
      .o_load_addr (dump_load_addr),
      .o_valid     (o_dump_valid),
      .o_addr      (o_dump_addr),
      .o_data      (o_dump_data),
      .o_busy      (o_dump_busy),
      .o_done      (o_dump_done)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp (32 regs zero-reg, 24 regs plain)
module tb_register_file_mp;

   localparam int NA = 32;
   localparam int NB = 24;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [9:0]  rd_addr;
   logic        start;
   logic        ready;

   logic [63:0] rdd   [2];
   logic        dv    [2];
   logic        dbusy [2];
   logic        ddone [2];
   logic [4:0]  daddr [2];
   logic [31:0] ddata [2];

   logic [31:0] mem [2][32];
   bit          active   [2];
   bit          done_due [2];
   int          cur      [2];
   int          beats    [2];
   beat_t       qa[$];
   beat_t       qb[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   register_file_mp #(.NB_DATA(32), .NB_ADDRESS(5), .N_REGISTERS(NA), .N_READ_PORTS(2), .ZERO_REG(1)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_addr(rd_addr), .o_rd_data(rdd[0]), .i_dump_start(start), .i_dump_ready(ready),
      .o_dump_valid(dv[0]), .o_dump_addr(daddr[0]), .o_dump_data(ddata[0]),
      .o_dump_busy(dbusy[0]), .o_dump_done(ddone[0]));

   register_file_mp #(.NB_DATA(32), .NB_ADDRESS(5), .N_REGISTERS(NB), .N_READ_PORTS(2), .ZERO_REG(0)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_addr(rd_addr), .o_rd_data(rdd[1]), .i_dump_start(start), .i_dump_ready(ready),
      .o_dump_valid(dv[1]), .o_dump_addr(daddr[1]), .o_dump_data(ddata[1]),
      .o_dump_busy(dbusy[1]), .o_dump_done(ddone[1]));

   function automatic int nreg(int i);
      return (i == 0) ? NA : NB;
   endfunction

   function automatic bit zr(int i);
      return (i == 0);
   endfunction

   function automatic logic [31:0] ref_read(int i, int unsigned a);
      if ((a >= nreg(i)) || (zr(i) && (a == 0)))
         return 32'h0;
      if (wr_en && (32'(wr_addr) == a))
         return wr_data;
      return mem[i][a];
   endfunction

   task automatic chk(int i, string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, i, $time, act, exp);
      end
   endtask

   task automatic push_beat(int i, int a);
      beat_t b;
      b.a = 5'(a);
      b.d = ref_read(i, a);
      if (i == 0) qa.push_back(b);
      else        qb.push_back(b);
   endtask

   task automatic model_step();
      bit was_done;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            active[i]   = 0;
            done_due[i] = 0;
            if (i == 0) qa.delete();
            else        qb.delete();
            for (int r = 0; r < 32; r++) mem[i][r] = 32'h0;
         end else begin
            was_done    = done_due[i];
            done_due[i] = 0;
            if (!active[i] && !was_done) begin
               if (start) begin
                  active[i] = 1;
                  cur[i]    = 0;
                  push_beat(i, 0);
               end
            end else if (active[i] && ready) begin
               if (cur[i] == nreg(i) - 1) begin
                  active[i]   = 0;
                  done_due[i] = 1;
               end else begin
                  cur[i]++;
                  push_beat(i, cur[i]);
               end
            end
            if (wr_en && (32'(wr_addr) < nreg(i)) && !(zr(i) && (wr_addr == 5'd0)))
               mem[i][wr_addr] = wr_data;
         end
      end
   endtask

   task automatic check_inst(int i);
      beat_t b;
      int    qs;
      chk(i, "dump_valid", 32'(dv[i]), 32'(active[i]));
      chk(i, "dump_busy", 32'(dbusy[i]), 32'(active[i] || done_due[i]));
      chk(i, "dump_done", 32'(ddone[i]), 32'(done_due[i]));
      if (dv[i]) begin
         qs = (i == 0) ? qa.size() : qb.size();
         chk(i, "beat_pending", 32'(qs != 0), 32'd1);
         if (qs != 0) begin
            b = (i == 0) ? qa[0] : qb[0];
            chk(i, "beat_addr", 32'(daddr[i]), 32'(b.a));
            chk(i, "beat_data", ddata[i], b.d);
            if (ready) begin
               if (i == 0) void'(qa.pop_front());
               else        void'(qb.pop_front());
               beats[i]++;
            end
         end
      end
      for (int p = 0; p < 2; p++)
         chk(i, $sformatf("rd_port%0d", p), rdd[i][p*32 +: 32], ref_read(i, 32'(rd_addr[p*5 +: 5])));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      check_inst(0);
      check_inst(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_all();
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         tick();
      end
   endtask

   task automatic wait_addr(int a);
      int c;
      for (c = 0; c < 200 && !(dv[0] && (daddr[0] == 5'(a))); c++) tick();
      chk(0, "wait_addr_timeout", 32'(c < 200), 32'd1);
   endtask

   task automatic wait_idle();
      int c;
      for (c = 0; c < 300 && (dbusy[0] || dbusy[1]); c++) tick();
      chk(0, "wait_idle_timeout", 32'(c < 300), 32'd1);
   endtask

   task automatic run_dump();
      beats[0] = 0;
      beats[1] = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; start = 1'b0; ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      read_all();

      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
      tick();
      wr_en = 1'b0;
      tick();
      chk(0, "r5_storage", rdd[0][31:0], 32'hDEADBEEF);

      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd0};
      #1 chk(0, "r7_bypass", rdd[0][63:32], 32'h12345678);
      tick();
      wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = '0;
      tick();
      wr_en = 1'b0;
      #1 chk(0, "r0_zero_reg", rdd[0][31:0], 32'h0);
      chk(1, "r0_plain", rdd[1][31:0], 32'hFFFFFFFF);
      tick();

      for (int k = 0; k < 32; k++) begin
         wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'h100 + 32'(k);
         tick();
      end
      wr_en = 1'b0;
      run_dump();
      wait_idle();
      chk(0, "beat_count", 32'(beats[0]), 32'd32);
      chk(1, "beat_count", 32'(beats[1]), 32'd24);
      tick();

      run_dump();
      wait_addr(4);
      ready = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAAAA; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      tick(); tick();
      chk(0, "held_addr", 32'(daddr[0]), 32'd4);
      chk(0, "held_data", ddata[0], 32'h104);
      ready = 1'b1;
      wait_idle();
      chk(0, "bp_beat_count", 32'(beats[0]), 32'd32);
      chk(1, "bp_beat_count", 32'(beats[1]), 32'd24);
      tick();

      run_dump();
      wait_addr(10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(0, "post_reset_busy", 32'(dbusy[0]), 32'd0);
      read_all();
      run_dump();
      chk(0, "restart_addr", 32'(daddr[0]), 32'd0);
      wait_idle();
      chk(0, "restart_beats", 32'(beats[0]), 32'd32);
      chk(1, "restart_beats", 32'(beats[1]), 32'd24);

      for (int n = 0; n < 500; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 5'($urandom);
         wr_data = $urandom;
         rd_addr = 10'($urandom);
         start   = ($urandom_range(0, 15) == 0);
         ready   = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; wr_en = 1'b0; start = 1'b0; ready = 1'b1;
      wait_idle();
      tick();
      chk(0, "queue_drained", 32'(qa.size()), 32'd0);
      chk(1, "queue_drained", 32'(qb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
